// File: rtl/mainfsm.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables, mux selects and the 2-bit aluop.
module mainfsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       memready,
    output logic       memwrite,
    output logic       irwrite,
    output logic       iord,
    output logic       pcwrite,
    output logic       branch,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       illegal
);

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    state_t state;
    state_t state_nxt;

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore output decode; FETCH enables are gated by reset
    // so nothing writes while reset is held.
    always_comb begin
        state_nxt = state;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        iord      = 1'b0;
        pcwrite   = 1'b0;
        branch    = 1'b0;
        pcsrc     = 2'b00;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        aluop     = 2'b00;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        regwrite  = 1'b0;
        illegal   = 1'b0;

        case (state)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = memready & reset;
                pcwrite = memready & reset;
                if (memready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_RTYPEEX;
                    OP_BEQ:       state_nxt = S_BEQEX;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_J:         state_nxt = S_JEX;
                    default: begin
                        illegal   = 1'b1;
                        state_nxt = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (op == OP_LW)      state_nxt = S_MEMRD;
                else if (op == OP_SW) state_nxt = S_MEMWR;
                else                  state_nxt = S_FETCH;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (memready) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg  = 1'b1;
                regwrite  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (memready) state_nxt = S_FETCH;
            end
            S_RTYPEEX: begin
                alusrca   = 1'b1;
                aluop     = 2'b10;
                state_nxt = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst    = 1'b1;
                regwrite  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BEQEX: begin
                alusrca   = 1'b1;
                aluop     = 2'b01;
                pcsrc     = 2'b01;
                branch    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                state_nxt = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JEX: begin
                pcsrc     = 2'b10;
                pcwrite   = 1'b1;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase

        pcen = pcwrite | (branch & zero);
    end

endmodule

// File: doc/mainfsm.md
# mainfsm

Multicycle MIPS main control state machine. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath enables and muxes, and produces the 2-bit `aluop` consumed by the ALU decoder. Memory accesses use a `memready` handshake so the core can stall on slow memory.

## Interface
- Parameters: none.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; low forces state FETCH immediately.
- `op`  in  6  opcode field of the instruction register (`instr[31:26]`).
- `zero`  in  1  ALU zero flag.
- `memready`  in  1  memory completes the current access this cycle.
- `memwrite`  out  1  memory write strobe.
- `irwrite`  out  1  instruction register load.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `pcwrite`  out  1  unconditional PC write.
- `branch`  out  1  conditional PC write.
- `pcen`  out  1  `pcwrite | (branch & zero)`.
- `pcsrc`  out  2  PC mux select: 00 ALU result, 01 ALUOut, 10 jump target.
- `alusrca`  out  1  ALU A select: 0 = PC, 1 = register A.
- `alusrcb`  out  2  ALU B select: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2.
- `aluop`  out  2  00 = add, 01 = sub, 10 = use funct.
- `regdst`  out  1  write register: 0 = rt, 1 = rd.
- `memtoreg`  out  1  writeback source: 0 = ALUOut, 1 = data register.
- `regwrite`  out  1  register file write.
- `illegal`  out  1  unsupported opcode seen in DECODE.

## Operation
- State register is 4 bits; the encoding is free.
- Outputs are Moore-decoded from state, except the `memready` gating in FETCH and `pcen`. Any output not listed for a state is 0.
- Opcodes:
  - LW = 100011
  - SW = 101011
  - RTYPE = 000000
  - BEQ = 000100
  - ADDI = 001000
  - J = 000010
- States, their outputs, and next state:
  - FETCH: `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=00, `pcsrc`=00. `irwrite`=`pcwrite`=`memready`. Next state is DECODE if `memready`, else FETCH.
  - DECODE: `alusrca`=0, `alusrcb`=11, `aluop`=00. Next state by `op`:
    - LW or SW → MEMADR
    - RTYPE → RTYPEEX
    - BEQ → BEQEX
    - ADDI → ADDIEX
    - J → JEX
    - any other opcode → FETCH with `illegal`=1 for this cycle
  - MEMADR: `alusrca`=1, `alusrcb`=10, `aluop`=00. Next: LW → MEMRD, SW → MEMWR.
  - MEMRD: `iord`=1. Next is MEMWB if `memready`, else MEMRD.
  - MEMWB: `regdst`=0, `memtoreg`=1, `regwrite`=1. Next: FETCH.
  - MEMWR: `iord`=1, `memwrite`=1, held every cycle in this state. Next is FETCH if `memready`, else MEMWR.
  - RTYPEEX: `alusrca`=1, `alusrcb`=00, `aluop`=10. Next: RTYPEWB.
  - RTYPEWB: `regdst`=1, `memtoreg`=0, `regwrite`=1. Next: FETCH.
  - BEQEX: `alusrca`=1, `alusrcb`=00, `aluop`=01, `pcsrc`=01, `branch`=1. Next: FETCH.
  - ADDIEX: `alusrca`=1, `alusrcb`=10, `aluop`=00. Next: ADDIWB.
  - ADDIWB: `regdst`=0, `memtoreg`=0, `regwrite`=1. Next: FETCH.
  - JEX: `pcsrc`=10, `pcwrite`=1. Next: FETCH.
- The `op` value used in MEMADR is sampled live. The instruction register is stable outside FETCH, so no local copy is needed.

## Timing
- Reset:
  - While `reset`=0, state = FETCH.
  - All enables are forced to 0: `irwrite`, `pcwrite`, `pcen`, `branch`, `regwrite`, `memwrite`, `illegal`.
  - Mux selects take their FETCH values (`alusrcb`=01, all others 0).
  - The first fetch can complete on the first rising edge after `reset` rises, if `memready`=1.
- Minimum cycles per instruction, with `memready` high:
  - LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3.
  - Illegal opcode: 2.
- Each cycle `memready` is low in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `memready` is ignored in all other states.
- `pcen` is combinational and updates in the same cycle as `zero`. A BEQ is taken iff `zero`=1 in the BEQEX cycle.
- Reset asserted mid-instruction, including during a MEMWR stall:
  - The state is abandoned immediately and `memwrite` drops asynchronously.
  - No partial writeback occurs.

## Test plan
- Reset, then `op`=LW with `memready` held 1: states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH.
  - `aluop` in the first three cycles is 00, 00, 00.
  - `regwrite`=1 and `memtoreg`=1 only in cycle 5.
- SW with `memready` low for 2 cycles in MEMWR: `memwrite`=1 for exactly 3 consecutive cycles, then FETCH.
- RTYPE: `aluop`=10 in exactly one cycle (RTYPEEX), followed by `regwrite`=1 with `regdst`=1.
- BEQ with `zero`=1: `pcen`=1 and `pcsrc`=01 in BEQEX. Repeat with `zero`=0: `pcen`=0.
- FETCH with `memready` low for 3 cycles: `irwrite`=0 for those 3 cycles, then `irwrite`=`pcen`=1 for one cycle.
- `op`=111111: `illegal`=1 for one cycle in DECODE, next state FETCH, and no write enables asserted.
- `reset` pulsed low during MEMRD: outputs immediately show FETCH values with all enables 0, and the sequence resumes from FETCH.
